// File: rtl/seq_mul_unit_pkg.sv
// Shared definitions for the iterative KGP-RISC multiplier (state encodings, widths, helpers).
package seq_mul_unit_pkg;

   localparam int unsigned WIDTH    = 32;
   localparam int unsigned CNT_W    = 6;
   localparam int unsigned MUL_ITER = 32;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ABS_A  = 3'd1,
      S_ABS_B  = 3'd2,
      S_RUN    = 3'd3,
      S_NEG_LO = 3'd4,
      S_NEG_HI = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   typedef struct packed {
      logic             is_signed;
      logic [WIDTH-1:0] op_a;
      logic [WIDTH-1:0] op_b;
   } mul_req_t;

   // Ripple increment built from gates so the 32-bit ADDER stays the only adder.
   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] x);
      logic             cy;
      logic [CNT_W-1:0] res;
      cy  = 1'b1;
      res = '0;
      for (int i = 0; i < int'(CNT_W); i++) begin
         res[i] = x[i] ^ cy;
         cy     = x[i] & cy;
      end
      return res;
   endfunction

endpackage

// File: rtl/seq_mul_unit_if.sv
// Start/busy/done handshake and operand/product bus between execute-stage controller and multiplier.
interface seq_mul_unit_if;
   import seq_mul_unit_pkg::*;

   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] prod_hi;
   logic [WIDTH-1:0] prod_lo;

   modport master (output start, is_signed, op_a, op_b,
                   input  busy, done, prod_hi, prod_lo);
   modport slave  (input  start, is_signed, op_a, op_b,
                   output busy, done, prod_hi, prod_lo);
endinterface

// File: rtl/seq_mul_unit_adder.sv
// Combinational 32-bit ADDER (A,B -> S,C) with carry-in tied to zero.
module seq_mul_unit_adder
   import seq_mul_unit_pkg::*;
(
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_s,
   output logic             o_c
);

   always_comb begin
      logic cy;
      cy  = 1'b0;
      o_s = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         o_s[i] = i_a[i] ^ i_b[i] ^ cy;
         cy     = (i_a[i] & i_b[i]) | ((i_a[i] ^ i_b[i]) & cy);
      end
      o_c = cy;
   end

endmodule

// File: rtl/seq_mul_unit_dp.sv
// Multiplier datapath: single ADDER instance, operand muxes, working and product registers.
// MUL_EARLY_TERM_EN: flags a zero operand so the controller can skip straight to DONE.
module seq_mul_unit_dp
   import seq_mul_unit_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  state_t           i_state,
   input  logic             i_load,
   input  mul_req_t         i_req,
   input  logic             i_ld_prod,
   input  logic             i_zero_prod,
   output logic [WIDTH-1:0] o_prod_hi,
   output logic [WIDTH-1:0] o_prod_lo,
   output logic             o_opz_c
);

   mul_req_t         r_req;
   logic             r_sneg;
   logic [WIDTH-1:0] r_m;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_cy;
   logic [WIDTH-1:0] r_prod_hi;
   logic [WIDTH-1:0] r_prod_lo;

   logic [WIDTH-1:0] w_add_a;
   logic [WIDTH-1:0] w_add_b;
   logic [WIDTH-1:0] w_sum;
   logic             w_co;
   logic [WIDTH:0]   w_step;
   logic [WIDTH-1:0] w_m_nxt;
   logic [WIDTH-1:0] w_hi_nxt;
   logic [WIDTH-1:0] w_lo_nxt;
   logic             w_cy_nxt;
   logic             w_neg_a;
   logic             w_neg_b;

   assign w_neg_a = r_req.is_signed & r_req.op_a[WIDTH-1];
   assign w_neg_b = r_req.is_signed & r_req.op_b[WIDTH-1];

   seq_mul_unit_adder u_adder (
      .i_a (w_add_a),
      .i_b (w_add_b),
      .o_s (w_sum),
      .o_c (w_co)
   );

   // Adder operand selection; two's-complement negation is ~x + 1 through the ADDER.
   always_comb begin
      w_add_a = '0;
      w_add_b = '0;
      case (i_state)
         S_ABS_A:  begin w_add_a = ~r_req.op_a; w_add_b = WIDTH'(1); end
         S_ABS_B:  begin w_add_a = ~r_req.op_b; w_add_b = WIDTH'(1); end
         S_RUN:    begin w_add_a = r_hi;        w_add_b = r_m;       end
         S_NEG_LO: begin w_add_a = ~r_lo;       w_add_b = WIDTH'(1); end
         S_NEG_HI: begin w_add_a = ~r_hi;       w_add_b = {{(WIDTH-1){1'b0}}, r_cy}; end
         default:  ;
      endcase
   end

   // Next values of the working registers for the current step.
   always_comb begin
      w_m_nxt  = r_m;
      w_hi_nxt = r_hi;
      w_lo_nxt = r_lo;
      w_cy_nxt = r_cy;
      w_step   = '0;
      case (i_state)
         S_ABS_A: w_m_nxt = w_neg_a ? w_sum : r_req.op_a;
         S_ABS_B: begin
            w_lo_nxt = w_neg_b ? w_sum : r_req.op_b;
            w_hi_nxt = '0;
         end
         S_RUN: begin
            w_step   = r_lo[0] ? {w_co, w_sum} : {1'b0, r_hi};
            w_hi_nxt = w_step[WIDTH:1];
            w_lo_nxt = {w_step[0], r_lo[WIDTH-1:1]};
         end
         S_NEG_LO: begin
            if (r_sneg) {w_cy_nxt, w_lo_nxt} = {w_co, w_sum};
            else        w_cy_nxt = 1'b0;
         end
         S_NEG_HI: if (r_sneg) w_hi_nxt = w_sum;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req     <= '0;
         r_sneg    <= 1'b0;
         r_m       <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_cy      <= 1'b0;
         r_prod_hi <= '0;
         r_prod_lo <= '0;
      end else begin
         if (i_load) begin
            r_req  <= i_req;
            r_sneg <= i_req.is_signed & (i_req.op_a[WIDTH-1] ^ i_req.op_b[WIDTH-1]);
         end
         r_m  <= w_m_nxt;
         r_hi <= w_hi_nxt;
         r_lo <= w_lo_nxt;
         r_cy <= w_cy_nxt;
         // Product captured on the edge that enters DONE, held otherwise.
         if (i_ld_prod) begin
            r_prod_hi <= i_zero_prod ? '0 : w_hi_nxt;
            r_prod_lo <= i_zero_prod ? '0 : w_lo_nxt;
         end
      end
   end

   assign o_prod_hi = r_prod_hi;
   assign o_prod_lo = r_prod_lo;

`ifdef MUL_EARLY_TERM_EN
   assign o_opz_c = (r_req.op_a == '0) | (r_req.op_b == '0);
`else
   assign o_opz_c = 1'b0;
`endif

endmodule

// File: rtl/seq_mul_unit.sv
// Iterative 32x32->64 signed/unsigned shift-add multiplier with start/busy/done handshake.
// Optional MUL_EARLY_TERM_EN: zero operand finishes three cycles after start.
module seq_mul_unit
   import seq_mul_unit_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   seq_mul_unit_if.slave bus
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_busy;
   logic             r_done;
   logic             w_load;
   logic             w_ld_prod;
   logic             w_zero_prod;
   logic             w_opz;
   mul_req_t         w_req;
   logic [WIDTH-1:0] w_prod_hi;
   logic [WIDTH-1:0] w_prod_lo;

   assign w_req = {bus.is_signed, bus.op_a, bus.op_b};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         r_done  <= (w_state_nxt == S_DONE);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_load      = 1'b0;
      w_ld_prod   = 1'b0;
      w_zero_prod = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_load      = 1'b1;
               w_state_nxt = S_ABS_A;
            end
         end
         S_ABS_A: w_state_nxt = S_ABS_B;
         S_ABS_B: begin
            w_cnt_nxt = '0;
            if (w_opz) begin
               w_state_nxt = S_DONE;
               w_ld_prod   = 1'b1;
               w_zero_prod = 1'b1;
            end else begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            w_cnt_nxt = cnt_inc(r_cnt);
            if (r_cnt == CNT_W'(MUL_ITER - 1)) w_state_nxt = S_NEG_LO;
         end
         S_NEG_LO: w_state_nxt = S_NEG_HI;
         S_NEG_HI: begin
            w_state_nxt = S_DONE;
            w_ld_prod   = 1'b1;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   seq_mul_unit_dp u_dp (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_state     (r_state),
      .i_load      (w_load),
      .i_req       (w_req),
      .i_ld_prod   (w_ld_prod),
      .i_zero_prod (w_zero_prod),
      .o_prod_hi   (w_prod_hi),
      .o_prod_lo   (w_prod_lo),
      .o_opz_c     (w_opz)
   );

   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.prod_hi = w_prod_hi;
   assign bus.prod_lo = w_prod_lo;

endmodule
